// File: rtl/rs_syndrome_engine.sv
// rs_syndrome_engine: streaming Reed-Solomon syndrome generator over GF(2^M).
// Every syndrome S_j = r(alpha^(FIRST_ROOT+j)) is built in parallel by Horner's
// rule, one received symbol per accepted beat, highest-degree symbol first.
module rs_syndrome_engine #(
  parameter int unsigned M          = 3,
  parameter int unsigned N          = 7,
  parameter int unsigned NSYN       = 2,
  parameter int unsigned FIRST_ROOT = 1,
  parameter logic [M:0]  PRIM_POLY  = 4'b1011
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [M-1:0]        in_sym,
  input  logic                in_last,
  output logic                syn_valid,
  input  logic                syn_ready,
  output logic [NSYN*M-1:0]   syn,
  output logic                syn_zero,
  output logic                err_len
);

  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
  localparam int unsigned SW = NSYN * M;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [SW-1:0] acc;
  logic [SW-1:0] acc_next;
  logic          beat;
  logic          last_cnt;
  logic          close;
  logic          release_syn;

  // Multiply by alpha (x) modulo the primitive polynomial.
  function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] a);
    logic [M-1:0] r;
    r = a << 1;
    if (a[M-1]) r = r ^ PRIM_POLY[M-1:0];
    return r;
  endfunction

  // alpha^e, evaluated at elaboration for the constant root of each syndrome.
  function automatic logic [M-1:0] gf_pow(input int unsigned e);
    logic [M-1:0] r;
    r = M'(1);
    for (int unsigned i = 0; i < e; i++) r = gf_xtime(r);
    return r;
  endfunction

  // Shift-and-add GF product; with a constant k it reduces to an XOR network.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] k);
    logic [M-1:0] p;
    logic [M-1:0] t;
    p = '0;
    t = a;
    for (int unsigned i = 0; i < M; i++) begin
      if (k[i]) p = p ^ t;
      t = gf_xtime(t);
    end
    return p;
  endfunction

  // One Horner step per syndrome: S_j * alpha^(b+j) + r_i.
  for (genvar j = 0; j < NSYN; j++) begin : g_syn
    localparam logic [M-1:0] ROOT = gf_pow(FIRST_ROOT + 32'(j));
    assign acc_next[j*M +: M] = gf_mul(acc[j*M +: M], ROOT) ^ in_sym;
  end

  // Handshake and frame-close decode.
  always_comb begin
    beat        = in_valid & in_ready;
    last_cnt    = (cnt == CNT_LAST);
    close       = beat & (in_last | last_cnt);
    release_syn = syn_valid & syn_ready;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = ACC;
      ACC:     if (close) state_next = DONE;
      DONE:    if (syn_ready) state_next = ACC;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    in_ready  = 1'b0;
    syn_valid = 1'b0;
    case (state)
      ACC:     in_ready  = 1'b1;
      DONE:    syn_valid = 1'b1;
      default: ;
    endcase
  end

  // Accumulators and symbol counter; cleared when the result is taken.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (release_syn) begin
      acc <= '0;
      cnt <= '0;
    end else if (beat) begin
      acc <= acc_next;
      cnt <= cnt + CW'(1);
    end
  end

  // Result registers, loaded only on the closing beat so they stay held in DONE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      syn      <= '0;
      syn_zero <= 1'b0;
      err_len  <= 1'b0;
    end else if (close) begin
      syn      <= acc_next;
      syn_zero <= (acc_next == '0);
      err_len  <= in_last ^ last_cnt;
    end
  end

endmodule

// File: tb/tb_rs_syndrome_engine.sv
// Directed bench for rs_syndrome_engine at default parameters (GF(8), N=7, 2 syndromes).
module tb_rs_syndrome_engine;

  localparam int unsigned M    = 3;
  localparam int unsigned N    = 7;
  localparam int unsigned NSYN = 2;
  localparam int unsigned SW   = NSYN * M;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [M-1:0]  in_sym;
  logic          in_last;
  logic          syn_valid;
  logic          syn_ready;
  logic [SW-1:0] syn;
  logic          syn_zero;
  logic          err_len;

  int checks = 0;
  int errors = 0;

  rs_syndrome_engine dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sym    (in_sym),
    .in_last   (in_last),
    .syn_valid (syn_valid),
    .syn_ready (syn_ready),
    .syn       (syn),
    .syn_zero  (syn_zero),
    .err_len   (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [M-1:0]  sym [N];
    int            len;
    int            last_pos;   // index carrying in_last, -1 for none
    bit            bubbles;
    logic [SW-1:0] exp_syn;
    logic          exp_zero;
    logic          exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive the symbols of one frame; returns right after the last accepted edge.
  task automatic send_syms(input vec_t v);
    int budget;
    for (int i = 0; i < v.len; i++) begin
      if (v.bubbles && ($urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) step();
      end
      in_valid = 1'b1;
      in_sym   = v.sym[i];
      in_last  = (i == v.last_pos);
      budget   = 0;
      while (!in_ready && budget < 20) begin
        step();
        budget++;
      end
      if (!in_ready) begin
        errors++;
        checks++;
        $display("FAIL %s_ready_timeout: in_ready stuck 0 at %0t", v.name, $time);
      end
      chk({v.name, "_busy_valid"}, 32'(syn_valid), 32'd0);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_sym   = '0;
  endtask

  // Check the held result in the cycle after the closing beat, then take it.
  task automatic take_result(input vec_t v);
    chk({v.name, "_valid"},   32'(syn_valid), 32'd1);
    chk({v.name, "_syn"},     32'(syn),       32'(v.exp_syn));
    chk({v.name, "_zero"},    32'(syn_zero),  32'(v.exp_zero));
    chk({v.name, "_err_len"}, 32'(err_len),   32'(v.exp_err));
    chk({v.name, "_done_rdy"}, 32'(in_ready), 32'd0);
    syn_ready = 1'b1;
    step();
    syn_ready = 1'b0;
    chk({v.name, "_released"}, 32'(syn_valid), 32'd0);
    chk({v.name, "_rdy_back"}, 32'(in_ready),  32'd1);
  endtask

  function automatic vec_t mk(input string nm, input logic [3*N-1:0] s, input int len,
                              input int lp, input bit bub, input logic [SW-1:0] es,
                              input logic ez, input logic ee);
    vec_t v;
    v.name = nm;
    for (int i = 0; i < N; i++) v.sym[i] = s[3*(N-1-i) +: 3];
    v.len      = len;
    v.last_pos = lp;
    v.bubbles  = bub;
    v.exp_syn  = es;
    v.exp_zero = ez;
    v.exp_err  = ee;
    return v;
  endfunction

  initial begin
    vec_t v;
    // Symbols listed first-sent to last-sent (r6 .. r0), 3 bits each.
    vecs[0] = mk("gen_poly",   {3'd0,3'd0,3'd0,3'd0,3'd1,3'd6,3'd3}, 7,  6, 0, 6'h00, 1'b1, 1'b0);
    vecs[1] = mk("r1_one",     {3'd0,3'd0,3'd0,3'd0,3'd0,3'd1,3'd0}, 7,  6, 0, 6'h22, 1'b0, 1'b0);
    vecs[2] = mk("r2_three_b", {3'd0,3'd0,3'd0,3'd0,3'd3,3'd0,3'd0}, 7,  6, 1, 6'h0F, 1'b0, 1'b0);
    vecs[3] = mk("r2_three",   {3'd0,3'd0,3'd0,3'd0,3'd3,3'd0,3'd0}, 7,  6, 0, 6'h0F, 1'b0, 1'b0);
    vecs[4] = mk("all_zero",   {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}, 7,  6, 0, 6'h00, 1'b1, 1'b0);
    vecs[5] = mk("r0_five",    {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd5}, 7,  6, 0, 6'h2D, 1'b0, 1'b0);
    vecs[6] = mk("r6_one",     {3'd1,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}, 7,  6, 1, 6'h3D, 1'b0, 1'b0);
    vecs[7] = mk("cw_plus_e",  {3'd0,3'd0,3'd0,3'd0,3'd1,3'd7,3'd3}, 7,  6, 0, 6'h22, 1'b0, 1'b0);
    vecs[8] = mk("early_last", {3'd1,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}, 5,  4, 0, 6'h16, 1'b0, 1'b1);
    vecs[9] = mk("no_last",    {3'd0,3'd0,3'd0,3'd0,3'd0,3'd1,3'd0}, 7, -1, 0, 6'h22, 1'b0, 1'b1);

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sym    = '0;
    in_last   = 1'b0;
    syn_ready = 1'b0;
    repeat (2) step();
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_syn_valid", 32'(syn_valid), 32'd0);
    chk("rst_syn",       32'(syn),       32'd0);
    chk("rst_syn_zero",  32'(syn_zero),  32'd0);
    chk("rst_err_len",   32'(err_len),   32'd0);
    reset_n = 1'b1;
    step();
    chk("idle_to_acc_rdy", 32'(in_ready), 32'd1);

    // Table-driven frames, each taken as soon as it is offered.
    for (int k = 0; k < 10; k++) begin
      send_syms(vecs[k]);
      take_result(vecs[k]);
    end

    // Held result under back-pressure; in_valid in DONE must not be consumed.
    v = vecs[1];
    send_syms(v);
    in_valid = 1'b1;
    in_sym   = 3'd7;
    for (int c = 0; c < 10; c++) begin
      chk("stall_valid", 32'(syn_valid), 32'd1);
      chk("stall_syn",   32'(syn),       32'h22);
      chk("stall_rdy",   32'(in_ready),  32'd0);
      step();
    end
    in_valid = 1'b0;
    in_sym   = '0;
    take_result(v);
    v = vecs[5];
    send_syms(v);
    take_result(v);

    // Reset after three beats of a frame whose syndrome is still partial.
    v = vecs[6];
    v.len = 3;
    v.last_pos = -1;
    send_syms(v);
    chk("pre_rst_no_valid", 32'(syn_valid), 32'd0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("mid_rst_rdy",   32'(in_ready),  32'd0);
    chk("mid_rst_valid", 32'(syn_valid), 32'd0);
    chk("mid_rst_syn",   32'(syn),       32'd0);
    chk("mid_rst_zero",  32'(syn_zero),  32'd0);
    chk("mid_rst_err",   32'(err_len),   32'd0);
    step();
    chk("post_rst_rdy",   32'(in_ready),  32'd1);
    chk("post_rst_valid", 32'(syn_valid), 32'd0);
    v = vecs[1];
    send_syms(v);
    take_result(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rs_syndrome_engine.md
# rs_syndrome_engine

Streaming, parametrised Reed-Solomon syndrome generator over GF(2^M). It accepts one received symbol per cycle through a valid/ready handshake. It evaluates all NSYN syndromes in parallel by Horner's rule and presents them, together with a zero-syndrome flag and a frame-length error flag, on a held output handshake. It is the front end of the RS decoder, replacing the fixed two-syndrome GF(8) calculator. It feeds the error-locator and corrector stages.

## Interface
Parameters:
- M, 3: symbol width in bits; field GF(2^M).
- N, 7: codeword length in symbols; legal range 2..2^M-1.
- NSYN, 2: number of syndromes (2T); legal range 1..N-1.
- FIRST_ROOT, 1: exponent b of the first root; syndrome j evaluates r(alpha^(b+j)).
- PRIM_POLY, 4'b1011: primitive polynomial, M+1 bits; default is x^3+x+1.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_sym/in_last are valid.
- in_ready  out  1  engine accepts a symbol this cycle.
- in_sym  in  M  received symbol in polynomial basis, highest degree (r_{N-1}) first.
- in_last  in  1  marks the final symbol of the frame.
- syn_valid  out  1  syndrome result is valid and held.
- syn_ready  in  1  downstream accepts the result.
- syn  out  NSYN*M  packed syndromes; syn[j*M +: M] = S_{b+j}.
- syn_zero  out  1  all syndromes zero (no detectable error).
- err_len  out  1  frame length differed from N.

## Operation
- States: IDLE, ACC, DONE. IDLE is entered on reset and lasts exactly one cycle before ACC.
- in_ready = (state == ACC). It is decoded from the state register with no combinational path from any input.
- Beat accepted = in_valid & in_ready. On each beat, for every j: S_j <= S_j * alpha^(b+j) XOR in_sym.
- Multipliers are constant GF multipliers. Constants come from PRIM_POLY at elaboration. No lookup RAM.
- A symbol counter cnt (width clog2(N)) increments per beat.
- The frame closes on the first beat with in_last=1, or on the beat with cnt==N-1, whichever comes first. That beat is accumulated. State then goes to DONE.
- err_len is latched at close as (in_last XOR cnt==N-1):
  - early in_last: err_len=1.
  - N symbols without in_last: err_len=1, and the frame still closes.
  - Symbols after a forced close belong to the next frame.
- In DONE: syn_valid=1, and syn, syn_zero, err_len are held stable. syn_zero = (all S_j == 0).
- DONE persists until syn_valid & syn_ready. On that cycle the accumulators clear to 0, cnt clears to 0, and state goes to ACC.
- in_valid low mid-frame (bubble): no change to state, cnt or S_j.
- Arithmetic: addition is bitwise XOR. No integer modulo. All intermediate values are exactly M bits wide.

## Timing
- Reset (reset_n=0 at a rising edge): state=IDLE, in_ready=0, syn_valid=0, syn=0, syn_zero=0, err_len=0, cnt=0, accumulators=0.
- in_ready rises on the first edge after reset_n returns high.
- Reset mid-frame or in DONE discards all partial or held results. No syn_valid is produced for the aborted frame.
- Latency: syn_valid rises on the edge that accepts the closing beat plus one cycle. In other words, it is high in the cycle after the closing beat.
- Throughput: with in_valid and syn_ready held high, one frame every N+1 cycles (N beats plus 1 DONE cycle).
- in_ready is 0 throughout DONE. in_valid during DONE is not accepted. The source must hold the symbol.
- syn, syn_zero and err_len change only when entering DONE or on reset.

## Test plan
- Defaults; stream 0,0,0,0,1,6,3 with in_last on the 7th symbol. This is g(x)=x^2+6x+3. -> syn=6'h00, syn_zero=1, err_len=0, syn_valid in the cycle after the 7th beat.
- Defaults; all-zero frame except value 1 as the 6th symbol (r_1). -> S1=2, S2=4, syn=6'h22, syn_zero=0.
- Defaults; value 3 as the 5th symbol (r_2), others zero, with random in_valid bubbles inserted. -> S1=7, S2=1, syn=6'h0F. Result is identical to the run without bubbles.
- Defaults; in_last on the 5th symbol -> syn_valid with err_len=1. Next, 7 symbols with no in_last -> frame closes after the 7th beat, err_len=1.
- syn_ready held low for 10 cycles in DONE -> syn_valid and syn are stable and in_ready=0 throughout. Once syn_ready rises, in_ready=1 in the next cycle, and a back-to-back second frame yields its own correct syndromes.
- reset_n pulsed low for one cycle after 3 beats -> all outputs are 0, in_ready=0 for the reset cycle and for IDLE. A following clean frame gives syn=6'h22 for the test-2 stimulus.
